// File: rtl/led_bar_peak_meter.sv
// LED bar/dot meter with a peak-hold marker: holds the highest level reached, then decays
// the marker one LED per step until it meets the live level.
module led_bar_peak_meter #(
  parameter int unsigned IN_W         = 4,
  parameter int unsigned N_LEDS       = 8,
  parameter int unsigned HOLD_CYCLES  = 25000000,
  parameter int unsigned DECAY_CYCLES = 5000000,
  localparam int unsigned LW          = $clog2(N_LEDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [IN_W-1:0]   sample,
  input  logic              dot_mode,
  input  logic              peak_en,
  input  logic              clear_peak,
  output logic [N_LEDS-1:0] leds,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     peak
);

  localparam int unsigned PW   = IN_W + LW;
  localparam int unsigned CMAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    StTrack = 2'd0,
    StHold  = 2'd1,
    StDecay = 2'd2
  } state_e;

  state_e          state_q;
  logic [LW-1:0]   level_q, peak_q;
  logic [CW-1:0]   hold_q, dec_q;
  logic [PW-1:0]   prod;
  logic [LW-1:0]   lvl_new, lvl_eff;

  // Rounds up so any non-zero sample lights at least one LED; PW bits cannot overflow.
  always_comb begin
    prod    = PW'(sample) * PW'(N_LEDS) + PW'({IN_W{1'b1}});
    lvl_new = LW'(prod >> IN_W);
    lvl_eff = sample_valid ? lvl_new : level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      peak_q  <= '0;
      state_q <= StTrack;
      hold_q  <= '0;
      dec_q   <= '0;
    end else begin
      if (sample_valid) level_q <= lvl_new;

      if (clear_peak) begin
        peak_q  <= lvl_eff;
        state_q <= StTrack;
        hold_q  <= '0;
        dec_q   <= '0;
      end else if (lvl_eff > peak_q) begin
        peak_q  <= lvl_eff;
        state_q <= StHold;
        hold_q  <= '0;
        dec_q   <= '0;
      end else begin
        unique case (state_q)
          StTrack: begin
            if (lvl_eff < peak_q) begin
              hold_q  <= '0;
              state_q <= StHold;
            end else begin
              peak_q <= lvl_eff;
            end
          end
          StHold: begin
            if (hold_q == CW'(HOLD_CYCLES - 1)) begin
              hold_q  <= '0;
              dec_q   <= '0;
              state_q <= StDecay;
            end else begin
              hold_q <= hold_q + CW'(1);
            end
          end
          StDecay: begin
            if (dec_q == CW'(DECAY_CYCLES - 1)) begin
              dec_q <= '0;
              // Guarded so the marker can never wrap below zero.
              if ((peak_q != '0) && ((peak_q - LW'(1)) > lvl_eff)) begin
                peak_q <= peak_q - LW'(1);
              end else begin
                peak_q  <= lvl_eff;
                state_q <= StTrack;
              end
            end else begin
              dec_q <= dec_q + CW'(1);
            end
          end
          default: state_q <= StTrack;
        endcase
      end
    end
  end

  always_comb begin
    leds = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (dot_mode) leds[i] = (level_q == LW'(i + 1));
      else          leds[i] = (LW'(i) < level_q);
      if (peak_en && (peak_q == LW'(i + 1))) leds[i] = 1'b1;
    end
  end

  assign level = level_q;
  assign peak  = peak_q;

endmodule

// File: tb/tb_led_bar_peak_meter.sv
// Directed bench for led_bar_peak_meter with a short hold (4) and decay step (2).
module tb_led_bar_peak_meter;

  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [3:0]    sample = '0;
  logic          dot_mode = 1'b0;
  logic          peak_en = 1'b0;
  logic          clear_peak = 1'b0;
  logic [7:0]    leds;
  logic [LW-1:0] level;
  logic [LW-1:0] peak;

  int n_checks = 0;
  int n_fails  = 0;

  led_bar_peak_meter #(
    .IN_W        (4),
    .N_LEDS      (8),
    .HOLD_CYCLES (4),
    .DECAY_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .dot_mode    (dot_mode),
    .peak_en     (peak_en),
    .clear_peak  (clear_peak),
    .leds        (leds),
    .level       (level),
    .peak        (peak)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] bar_tbl [16];
  int         exp_pk;

  initial begin
    bar_tbl = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h03, 8'h07, 8'h07, 8'h0F,
                8'h0F, 8'h1F, 8'h1F, 8'h3F, 8'h3F, 8'h7F, 8'h7F, 8'hFF};

    // Reset state
    #12;
    chk("rst_leds", 16'(leds), 16'h00);
    chk("rst_level", 16'(level), 16'h0);
    chk("rst_peak", 16'(peak), 16'h0);
    rst_n = 1'b1;
    tick();

    // Bar sweep
    for (int v = 0; v < 16; v++) begin
      sample = 4'(v);
      sample_valid = 1'b1;
      tick();
      chk($sformatf("bar_leds_%0d", v), 16'(leds), 16'(bar_tbl[v]));
      chk($sformatf("bar_level_%0d", v), 16'(level), 16'((v + 1) / 2));
    end

    // Level held without sample_valid
    sample_valid = 1'b0;
    sample = 4'd3;
    tick();
    chk("hold_level", 16'(level), 16'd8);

    // Dot mode
    dot_mode = 1'b1;
    sample_valid = 1'b1;
    sample = 4'd0;  tick(); chk("dot_0", 16'(leds), 16'h00);
    sample = 4'd1;  tick(); chk("dot_1", 16'(leds), 16'h01);
    sample = 4'd9;  tick(); chk("dot_9", 16'(leds), 16'h10);
    sample = 4'd15; tick(); chk("dot_15", 16'(leds), 16'h80);
    dot_mode = 1'b0;

    // Clear to zero, then peak hold and full decay
    clear_peak = 1'b1;
    sample = 4'd0;
    tick();
    clear_peak = 1'b0;
    chk("clr0_peak", 16'(peak), 16'd0);
    peak_en = 1'b1;
    sample = 4'd15; tick();
    chk("pk_rise_peak", 16'(peak), 16'd8);
    chk("pk_rise_state", 16'(dut.state_q), 16'd1);
    sample = 4'd2; tick();
    sample_valid = 1'b0;
    chk("pk_drop_level", 16'(level), 16'd1);
    chk("pk_drop_leds", 16'(leds), 16'h81);
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_pk = (k < 5) ? 8 : 7 - (k - 5) / 2;
      chk($sformatf("decay_peak_k%0d", k), 16'(peak), 16'(exp_pk));
      if (k < 4) chk($sformatf("decay_leds_k%0d", k), 16'(leds), 16'h81);
      if (k == 16) chk("decay_state_k16", 16'(dut.state_q), 16'd2);
    end
    chk("decay_end_state", 16'(dut.state_q), 16'd0);
    chk("decay_end_leds", 16'(leds), 16'h01);

    // Rise during decay restarts hold
    sample_valid = 1'b1;
    sample = 4'd15; tick();
    sample = 4'd2;  tick();
    sample_valid = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    chk("int_peak5", 16'(peak), 16'd5);
    chk("int_state_decay", 16'(dut.state_q), 16'd2);
    sample_valid = 1'b1;
    sample = 4'd13;
    tick();
    sample_valid = 1'b0;
    chk("int_level", 16'(level), 16'd7);
    chk("int_peak", 16'(peak), 16'd7);
    chk("int_state", 16'(dut.state_q), 16'd1);
    chk("int_hold_cnt", 16'(dut.hold_q), 16'd0);
    tick();
    chk("int_hold_cnt1", 16'(dut.hold_q), 16'd1);
    chk("int_leds", 16'(leds), 16'h7F);

    // clear_peak in HOLD together with a new sample
    sample_valid = 1'b1;
    sample = 4'd15; tick();
    sample = 4'd2;  tick();
    chk("clr_pre_peak", 16'(peak), 16'd8);
    chk("clr_pre_state", 16'(dut.state_q), 16'd1);
    clear_peak = 1'b1;
    sample = 4'd6;
    tick();
    clear_peak = 1'b0;
    sample_valid = 1'b0;
    chk("clr_level", 16'(level), 16'd3);
    chk("clr_peak", 16'(peak), 16'd3);
    chk("clr_state", 16'(dut.state_q), 16'd0);
    chk("clr_leds", 16'(leds), 16'h07);

    // Asynchronous reset mid-decay
    sample_valid = 1'b1;
    sample = 4'd15; tick();
    sample = 4'd2;  tick();
    sample_valid = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("ar_pre_peak", 16'(peak), 16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_leds", 16'(leds), 16'h00);
    chk("ar_level", 16'(level), 16'd0);
    chk("ar_peak", 16'(peak), 16'd0);
    #3;
    rst_n = 1'b1;
    tick();
    sample_valid = 1'b1;
    sample = 4'd9;
    tick();
    sample_valid = 1'b0;
    chk("ar_post_level", 16'(level), 16'd5);
    chk("ar_post_peak", 16'(peak), 16'd5);
    chk("ar_post_leds", 16'(leds), 16'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
